// File: rtl/msdft_corr_pkg.sv
// msdft_corr_pkg: shared width derivations and pipeline latency for the MSDFT correlator
package msdft_corr_pkg;
  localparam int CORR_LATENCY = 4;
  localparam int MULT_LATENCY = CORR_LATENCY - 1;
  function automatic int prod_width(input int din_width);
    return 2 * din_width + 1;
  endfunction
  function automatic int dout_width(input int din_width, input int acc_len_width);
    return prod_width(din_width) + acc_len_width;
  endfunction
endpackage

// File: rtl/msdft_corr_mult.sv
// msdft_corr_mult: registered auto-power and cross-product terms, fixed 3-cycle latency
module msdft_corr_mult
  import msdft_corr_pkg::*;
#(
  parameter int DIN_WIDTH  = 32,
  parameter int PROD_WIDTH = prod_width(DIN_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DIN_WIDTH-1:0]  a_re,
  input  logic signed [DIN_WIDTH-1:0]  a_im,
  input  logic signed [DIN_WIDTH-1:0]  b_re,
  input  logic signed [DIN_WIDTH-1:0]  b_im,
  input  logic                         din_valid,
  output logic signed [PROD_WIDTH-1:0] p0,
  output logic signed [PROD_WIDTH-1:0] p1,
  output logic signed [PROD_WIDTH-1:0] c_re,
  output logic signed [PROD_WIDTH-1:0] c_im,
  output logic                         dout_valid
);
  localparam int MW = 2 * DIN_WIDTH;
  logic signed [DIN_WIDTH-1:0] ar, ai, br, bi;
  logic signed [MW-1:0] ar_ar, ai_ai, br_br, bi_bi, ar_br, ai_bi, ai_br, ar_bi;
  logic v1, v2;
  always_ff @(posedge clk) begin
    if (rst) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      v1         <= din_valid;
      v2         <= v1;
      dout_valid <= v2;
    end
  end
  // datapath is qualified only by the valid chain, so it needs no reset
  always_ff @(posedge clk) begin
    ar    <= a_re;
    ai    <= a_im;
    br    <= b_re;
    bi    <= b_im;
    ar_ar <= MW'(ar) * MW'(ar);
    ai_ai <= MW'(ai) * MW'(ai);
    br_br <= MW'(br) * MW'(br);
    bi_bi <= MW'(bi) * MW'(bi);
    ar_br <= MW'(ar) * MW'(br);
    ai_bi <= MW'(ai) * MW'(bi);
    ai_br <= MW'(ai) * MW'(br);
    ar_bi <= MW'(ar) * MW'(bi);
    p0    <= PROD_WIDTH'(ar_ar) + PROD_WIDTH'(ai_ai);
    p1    <= PROD_WIDTH'(br_br) + PROD_WIDTH'(bi_bi);
    c_re  <= PROD_WIDTH'(ar_br) + PROD_WIDTH'(ai_bi);
    c_im  <= PROD_WIDTH'(ai_br) - PROD_WIDTH'(ar_bi);
  end
endmodule

// File: rtl/msdft_xcorr_acc.sv
// msdft_xcorr_acc: frame integrator of |X0|^2, |X1|^2 and X0*conj(X1) over acc_len valid samples
module msdft_xcorr_acc
  import msdft_corr_pkg::*;
#(
  parameter int DIN_WIDTH     = 32,
  parameter int DIN_POINT     = 16,
  parameter int ACC_LEN_WIDTH = 16,
  localparam int PROD_WIDTH   = prod_width(DIN_WIDTH),
  localparam int DOUT_WIDTH   = dout_width(DIN_WIDTH, ACC_LEN_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DIN_WIDTH-1:0]     din0_re,
  input  logic [DIN_WIDTH-1:0]     din0_im,
  input  logic [DIN_WIDTH-1:0]     din1_re,
  input  logic [DIN_WIDTH-1:0]     din1_im,
  input  logic                     din_valid,
  input  logic [ACC_LEN_WIDTH-1:0] acc_len,
  output logic [DOUT_WIDTH-1:0]    pow0,
  output logic [DOUT_WIDTH-1:0]    pow1,
  output logic [DOUT_WIDTH-1:0]    corr_re,
  output logic [DOUT_WIDTH-1:0]    corr_im,
  output logic                     dout_valid,
  output logic [31:0]              frame_cnt
);
  logic [ACC_LEN_WIDTH-1:0] len_r, cnt, len_eff;
  logic last, prod_valid, frame_end;
  logic [MULT_LATENCY-1:0] last_sr;
  logic signed [PROD_WIDTH-1:0] p0, p1, c_re, c_im;
  logic signed [DOUT_WIDTH-1:0] acc_p0, acc_p1, acc_re, acc_im;
  logic signed [DOUT_WIDTH-1:0] sum_p0, sum_p1, sum_re, sum_im;
  msdft_corr_mult #(
    .DIN_WIDTH (DIN_WIDTH),
    .PROD_WIDTH(PROD_WIDTH)
  ) u_mult (
    .clk       (clk),
    .rst       (rst),
    .a_re      (din0_re),
    .a_im      (din0_im),
    .b_re      (din1_re),
    .b_im      (din1_im),
    .din_valid (din_valid),
    .p0        (p0),
    .p1        (p1),
    .c_re      (c_re),
    .c_im      (c_im),
    .dout_valid(prod_valid)
  );
  // frame boundaries are decided at the input so acc_len is captured with the frame's
  // first sample; the end-of-frame flag then rides alongside the product pipeline
  always_comb begin
    len_eff   = cnt != '0 ? len_r : acc_len != '0 ? acc_len : ACC_LEN_WIDTH'(1);
    last      = cnt + ACC_LEN_WIDTH'(1) == len_eff;
    frame_end = prod_valid & last_sr[MULT_LATENCY-1];
    sum_p0    = acc_p0 + DOUT_WIDTH'(p0);
    sum_p1    = acc_p1 + DOUT_WIDTH'(p1);
    sum_re    = acc_re + DOUT_WIDTH'(c_re);
    sum_im    = acc_im + DOUT_WIDTH'(c_im);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      len_r   <= '0;
      last_sr <= '0;
    end else begin
      last_sr <= {last_sr[MULT_LATENCY-2:0], din_valid & last};
      if (din_valid) begin
        len_r <= len_eff;
        cnt   <= last ? '0 : cnt + ACC_LEN_WIDTH'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p0     <= '0;
      acc_p1     <= '0;
      acc_re     <= '0;
      acc_im     <= '0;
      pow0       <= '0;
      pow1       <= '0;
      corr_re    <= '0;
      corr_im    <= '0;
      dout_valid <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      dout_valid <= frame_end;
      if (prod_valid) begin
        acc_p0 <= frame_end ? '0 : sum_p0;
        acc_p1 <= frame_end ? '0 : sum_p1;
        acc_re <= frame_end ? '0 : sum_re;
        acc_im <= frame_end ? '0 : sum_im;
      end
      if (frame_end) begin
        pow0      <= sum_p0;
        pow1      <= sum_p1;
        corr_re   <= sum_re;
        corr_im   <= sum_im;
        frame_cnt <= frame_cnt + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_msdft_xcorr_acc.sv
// tb_msdft_xcorr_acc: directed self-checking bench for msdft_xcorr_acc
module tb_msdft_xcorr_acc;
  localparam int OW = 81;
  logic clk, rst, din_valid, dout_valid;
  logic [31:0] din0_re, din0_im, din1_re, din1_im, frame_cnt;
  logic [15:0] acc_len;
  logic [OW-1:0] pow0, pow1, corr_re, corr_im;
  int n_chk, n_pass;
  msdft_xcorr_acc dut (
    .clk(clk), .rst(rst),
    .din0_re(din0_re), .din0_im(din0_im), .din1_re(din1_re), .din1_im(din1_im),
    .din_valid(din_valid), .acc_len(acc_len),
    .pow0(pow0), .pow1(pow1), .corr_re(corr_re), .corr_im(corr_im),
    .dout_valid(dout_valid), .frame_cnt(frame_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    din_valid = 1'b0;
    step;
    step;
    rst = 1'b0;
  endtask
  task automatic set_ab(input logic [31:0] ar, ai, br, bi);
    din0_re = ar;
    din0_im = ai;
    din1_re = br;
    din1_im = bi;
  endtask
  task automatic test_reset;
    set_ab(0, 0, 0, 0);
    acc_len = 16'd4;
    do_reset;
    rst = 1'b1;
    step;
    n_chk++; if (dout_valid !== 1'b0) $display("FAIL reset_dout_valid got %0d want 0", dout_valid); else n_pass++;
    n_chk++; if (frame_cnt !== 32'd0) $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); else n_pass++;
    n_chk++; if (pow0 !== '0 || pow1 !== '0) $display("FAIL reset_pow got %0d/%0d want 0/0", pow0, pow1); else n_pass++;
    n_chk++; if (corr_re !== '0 || corr_im !== '0) $display("FAIL reset_corr got %0d/%0d want 0/0", corr_re, corr_im); else n_pass++;
    rst = 1'b0;
  endtask
  task automatic test_acc4;
    int cc;
    logic exp_v;
    do_reset;
    set_ab(3, 4, 1, 2);
    acc_len = 16'd4;
    for (int c = 0; c <= 16; c++) begin
      din_valid = c < 12;
      step;
      cc = c + 1;
      exp_v = cc == 7 || cc == 11 || cc == 15;
      n_chk++; if (dout_valid !== exp_v) $display("FAIL acc4_valid cyc %0d got %0d want %0d", cc, dout_valid, exp_v); else n_pass++;
      if (cc == 7 || cc == 13) begin
        n_chk++; if (pow0 !== OW'(100)) $display("FAIL acc4_pow0 cyc %0d got %0d want 100", cc, pow0); else n_pass++;
        n_chk++; if (pow1 !== OW'(20)) $display("FAIL acc4_pow1 cyc %0d got %0d want 20", cc, pow1); else n_pass++;
        n_chk++; if (corr_re !== OW'(44)) $display("FAIL acc4_corr_re cyc %0d got %0d want 44", cc, $signed(corr_re)); else n_pass++;
        n_chk++; if (corr_im !== OW'(-8)) $display("FAIL acc4_corr_im cyc %0d got %0d want -8", cc, $signed(corr_im)); else n_pass++;
      end
    end
    n_chk++; if (frame_cnt !== 32'd3) $display("FAIL acc4_frame_cnt got %0d want 3", frame_cnt); else n_pass++;
  endtask
  task automatic test_len1;
    int cc;
    logic exp_v;
    do_reset;
    set_ab(-32'sd5, 0, 0, 3);
    acc_len = 16'd1;
    for (int c = 0; c <= 12; c++) begin
      din_valid = c < 8;
      step;
      cc = c + 1;
      exp_v = cc >= 4 && cc <= 11;
      n_chk++; if (dout_valid !== exp_v) $display("FAIL len1_valid cyc %0d got %0d want %0d", cc, dout_valid, exp_v); else n_pass++;
      if (exp_v) begin
        n_chk++; if (frame_cnt !== 32'(cc - 3)) $display("FAIL len1_frame_cnt cyc %0d got %0d want %0d", cc, frame_cnt, cc - 3); else n_pass++;
      end
      if (cc == 6) begin
        n_chk++; if (pow0 !== OW'(25) || pow1 !== OW'(9)) $display("FAIL len1_pow got %0d/%0d want 25/9", pow0, pow1); else n_pass++;
        n_chk++; if (corr_re !== OW'(0)) $display("FAIL len1_corr_re got %0d want 0", $signed(corr_re)); else n_pass++;
        n_chk++; if (corr_im !== OW'(15)) $display("FAIL len1_corr_im got %0d want 15", $signed(corr_im)); else n_pass++;
      end
    end
  endtask
  task automatic test_gaps;
    int cc;
    logic [5:0] pat;
    pat = 6'b101001;
    do_reset;
    set_ab(1, 1, 1, 1);
    acc_len = 16'd3;
    for (int c = 0; c <= 14; c++) begin
      din_valid = c < 6 ? pat[c] : 1'b0;
      step;
      cc = c + 1;
      n_chk++; if (dout_valid !== (cc == 9)) $display("FAIL gaps_valid cyc %0d got %0d want %0d", cc, dout_valid, cc == 9); else n_pass++;
      if (cc == 9) begin
        n_chk++; if (pow0 !== OW'(6) || pow1 !== OW'(6)) $display("FAIL gaps_pow got %0d/%0d want 6/6", pow0, pow1); else n_pass++;
        n_chk++; if (corr_re !== OW'(6) || corr_im !== OW'(0)) $display("FAIL gaps_corr got %0d/%0d want 6/0", $signed(corr_re), $signed(corr_im)); else n_pass++;
      end
    end
    n_chk++; if (frame_cnt !== 32'd1) $display("FAIL gaps_frame_cnt got %0d want 1", frame_cnt); else n_pass++;
  endtask
  task automatic test_len_change;
    int cc;
    logic exp_v;
    do_reset;
    set_ab(3, 4, 1, 2);
    acc_len = 16'd4;
    for (int c = 0; c <= 16; c++) begin
      din_valid = c < 12;
      if (c == 2) acc_len = 16'd2;
      step;
      cc = c + 1;
      exp_v = cc == 7 || cc == 9 || cc == 11 || cc == 13 || cc == 15;
      n_chk++; if (dout_valid !== exp_v) $display("FAIL lenchg_valid cyc %0d got %0d want %0d", cc, dout_valid, exp_v); else n_pass++;
      if (cc == 7) begin
        n_chk++; if (pow0 !== OW'(100)) $display("FAIL lenchg_first_pow0 got %0d want 100", pow0); else n_pass++;
      end
      if (cc == 9 || cc == 15) begin
        n_chk++; if (pow0 !== OW'(50)) $display("FAIL lenchg_pow0 cyc %0d got %0d want 50", cc, pow0); else n_pass++;
      end
    end
    n_chk++; if (frame_cnt !== 32'd5) $display("FAIL lenchg_frame_cnt got %0d want 5", frame_cnt); else n_pass++;
  endtask
  task automatic test_mid_reset;
    int cc;
    set_ab(3, 4, 1, 2);
    acc_len = 16'd4;
    for (int c = 0; c < 2; c++) begin
      din_valid = 1'b1;
      step;
    end
    rst = 1'b1;
    din_valid = 1'b0;
    step;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step;
      n_chk++; if (dout_valid !== 1'b0) $display("FAIL midrst_valid cyc %0d got %0d want 0", c, dout_valid); else n_pass++;
    end
    n_chk++; if (pow0 !== '0 || corr_re !== '0) $display("FAIL midrst_outputs got %0d/%0d want 0/0", pow0, corr_re); else n_pass++;
    n_chk++; if (frame_cnt !== 32'd0) $display("FAIL midrst_frame_cnt got %0d want 0", frame_cnt); else n_pass++;
    for (int c = 0; c <= 9; c++) begin
      din_valid = c < 4;
      step;
      cc = c + 1;
      n_chk++; if (dout_valid !== (cc == 7)) $display("FAIL midrst_frame_valid cyc %0d got %0d want %0d", cc, dout_valid, cc == 7); else n_pass++;
      if (cc == 7) begin
        n_chk++; if (pow0 !== OW'(100) || corr_im !== OW'(-8)) $display("FAIL midrst_frame got %0d/%0d want 100/-8", pow0, $signed(corr_im)); else n_pass++;
      end
    end
    n_chk++; if (frame_cnt !== 32'd1) $display("FAIL midrst_frame_cnt2 got %0d want 1", frame_cnt); else n_pass++;
  endtask
  task automatic test_extreme;
    int cc, pulses;
    logic [OW-1:0] big;
    big = OW'(65535) << 63;
    pulses = 0;
    do_reset;
    set_ab(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    acc_len = 16'hFFFF;
    for (int c = 0; c <= 65540; c++) begin
      din_valid = c < 65535;
      step;
      cc = c + 1;
      if (dout_valid) pulses++;
      if (cc == 65538) begin
        n_chk++; if (dout_valid !== 1'b1) $display("FAIL ext_valid got %0d want 1", dout_valid); else n_pass++;
        n_chk++; if (pow0 !== big || pow1 !== big) $display("FAIL ext_pow got %h/%h want %h", pow0, pow1, big); else n_pass++;
        n_chk++; if (corr_re !== big) $display("FAIL ext_corr_re got %h want %h", corr_re, big); else n_pass++;
        n_chk++; if (corr_im !== '0) $display("FAIL ext_corr_im got %h want 0", corr_im); else n_pass++;
      end
    end
    n_chk++; if (pulses != 1) $display("FAIL ext_pulses got %0d want 1", pulses); else n_pass++;
    n_chk++; if (frame_cnt !== 32'd1) $display("FAIL ext_frame_cnt got %0d want 1", frame_cnt); else n_pass++;
  endtask
  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    din_valid = 1'b0;
    test_reset;
    test_acc4;
    test_len1;
    test_gaps;
    test_len_change;
    test_mid_reset;
    test_extreme;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/msdft_xcorr_acc.md
# msdft_xcorr_acc

Cross-correlator and integrator that sits directly downstream of two single-bin MSDFT channels. It takes the complex bin outputs X0 and X1, which share a valid strobe, and forms three terms per sample: the auto-powers |X0|², |X1|² and the cross-product X0·conj(X1). It sums these terms over a run-time-programmable number of valid samples and presents each finished frame with a one-cycle strobe. Its results feed the PS-side readout registers.

## Interface
Parameters:
- DIN_WIDTH, 32: width of each signed input component (matches MSDFT DOUT_WIDTH).
- DIN_POINT, 16: fractional bits of the inputs. All outputs carry 2*DIN_POINT fractional bits.
- ACC_LEN_WIDTH, 16: width of the acc_len port. The maximum frame is 2^ACC_LEN_WIDTH−1 samples.
- Derived localparams:
  - PROD_WIDTH = 2*DIN_WIDTH+1.
  - DOUT_WIDTH = PROD_WIDTH+ACC_LEN_WIDTH.

Ports:
- clk, in, 1: single clock; all logic is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- din0_re, din0_im, in, DIN_WIDTH each: bin X0, signed.
- din1_re, din1_im, in, DIN_WIDTH each: bin X1, signed.
- din_valid, in, 1: qualifies both bins in the same cycle.
- acc_len, in, ACC_LEN_WIDTH: number of valid samples per frame. 0 is treated as 1.
- pow0, pow1, out, DOUT_WIDTH each: unsigned accumulated auto-powers, MSB always 0.
- corr_re, corr_im, out, DOUT_WIDTH each: signed accumulated cross-product.
- dout_valid, out, 1: one-cycle pulse when a frame completes.
- frame_cnt, out, 32: number of frames completed since reset; wraps modulo 2^32.

## Operation
- Per valid sample, with a = din0 and b = din1:
  - p0 = a_re² + a_im².
  - p1 = b_re² + b_im².
  - c_re = a_re·b_re + a_im·b_im.
  - c_im = a_im·b_re − a_re·b_im.
- All products are full precision and sign-extended to PROD_WIDTH. There is no rounding and no saturation. The accumulator width guarantees no overflow for frames up to 2^ACC_LEN_WIDTH−1 samples.
- acc_len is sampled into len_r on the first valid sample of each frame, including the first frame after reset. Changes on the port while a frame is running take effect at the next frame.
- A sample counter counts products as they enter the accumulator.
- On the product whose count equals len_r:
  - The completed sums (including that product) are copied to the output registers.
  - dout_valid pulses and frame_cnt increments.
  - The counter resets.
  - The accumulators clear to 0 in the same cycle, so the next product starts a fresh frame with no lost samples.
- Cycles where din_valid is low are ignored. Gaps of any length within a frame are allowed.
- Output registers hold their values between pulses.

## Timing
- Pipeline stages:
  - S1: input registers.
  - S2: the eight products.
  - S3: adds and subtracts.
  - S4: accumulators and sample counter.
- The output registers load on the S4 edge at frame completion.
- Latency: if the final sample of a frame is presented with din_valid high in cycle k, dout_valid is high in cycle k+4 for exactly one cycle. The new outputs are valid in that same cycle.
- Throughput: one sample per cycle. Back-to-back frames with acc_len=1 give dout_valid high on every cycle of a continuous valid stream.
- Reset values:
  - All outputs 0, dout_valid 0, frame_cnt 0.
  - Accumulators, counter and pipeline valids 0; len_r 0.
- Reset mid-frame discards the partial frame and all in-flight pipeline samples. No dout_valid is produced for them.
- The first valid sample after rst deasserts starts a new frame.

## Structure
- Package msdft_corr_pkg holds:
  - the PROD_WIDTH/DOUT_WIDTH derivation functions;
  - the S1–S4 latency constant (4), shared with the readout block.
- Sub-module msdft_corr_mult implements S1–S3: four inputs plus valid in, p0/p1/c_re/c_im plus valid out, fixed 3-cycle latency. The top level holds the counter, len_r latch, accumulators and output registers.

## Test plan
- Constant a=(3,4), b=(1,2), acc_len=4, continuous valid -> pow0=100, pow1=20, corr_re=44, corr_im=−8. dout_valid is every 4th cycle, first pulse 4 cycles after the 4th sample.
- acc_len=1, a=(−5,0), b=(0,3) -> every cycle pow0=25, pow1=9, corr_re=0, corr_im=+15 (conjugate sign check). frame_cnt increments each cycle.
- acc_len=3 with valid as a 1-0-0-1-0-1 pattern, a=b=(1,1) -> a single pulse 4 cycles after the 3rd valid: pow0=pow1=6, corr_re=6, corr_im=0.
- acc_len changed 4->2 mid-frame -> the current frame still sums 4 samples; the following frames sum 2.
- rst asserted after 2 of 4 samples -> no pulse and all outputs 0. The next 4 samples give a clean 4-sample frame.
- Extreme inputs a=b=(−2^31, −2^31), acc_len=65535 -> pow0 = 65535·2^63 exactly, with no wrap or sign flip.
